// File: rtl/riscv_m_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package riscv_m_pkg;

    // Major opcode and funct7 that mark an M-extension instruction
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // funct3 encodings of the RV32M ops
    typedef enum logic [2:0] {
        M_MUL    = 3'd0,
        M_MULH   = 3'd1,
        M_MULHSU = 3'd2,
        M_MULHU  = 3'd3,
        M_DIV    = 3'd4,
        M_DIVU   = 3'd5,
        M_REM    = 3'd6,
        M_REMU   = 3'd7
    } m_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Divide/remainder ops all have funct3[2] set
    function automatic logic op_is_div(input m_op_e op);
        return op[2];
    endfunction

    // Remainder ops (REM/REMU) have funct3[1] set within the divide group
    function automatic logic op_is_rem(input m_op_e op);
        return op[2] & op[1];
    endfunction

    // Ops whose rs1 operand is interpreted as signed
    function automatic logic op_a_signed(input m_op_e op);
        return (op == M_MULH) || (op == M_MULHSU) || (op == M_DIV) || (op == M_REM);
    endfunction

    // Ops whose rs2 operand is interpreted as signed
    function automatic logic op_b_signed(input m_op_e op);
        return (op == M_MULH) || (op == M_DIV) || (op == M_REM);
    endfunction

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration of the shared datapath: a shift-add multiply step
// or a restoring divide step, chosen by is_div. Purely combinational so
// several copies can be chained to retire more than one bit per clock.
//
// Multiply: {acc,lo} is the partial product, lo holds the unconsumed
//   multiplier bits; add opb when lo[0] is set, then shift right.
// Divide:   lo holds the unconsumed dividend bits, acc the partial
//   remainder; shift the next dividend bit into acc, subtract opb if it
//   fits, and shift the quotient bit into lo[0].
module md_step #(
    parameter int DATA_W = 32
) (
    input  logic              is_div,
    input  logic [DATA_W-1:0] opb,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] acc_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   sh;
    logic [DATA_W+1:0] diff;
    logic              unused_diff_hi;

    // Bit DATA_W of the trial difference is always zero when the subtract
    // is kept, because the partial remainder stays below the divisor.
    assign unused_diff_hi = diff[DATA_W];

    // Select between the multiply and divide step for this bit
    always_comb begin
        sum  = {1'b0, acc_i} + (lo_i[0] ? {1'b0, opb} : '0);
        sh   = {acc_i, lo_i[DATA_W-1]};
        diff = {1'b0, sh} - {2'b00, opb};
        if (is_div) begin
            if (!diff[DATA_W+1]) begin
                acc_o = diff[DATA_W-1:0];
                lo_o  = {lo_i[DATA_W-2:0], 1'b1};
            end else begin
                acc_o = sh[DATA_W-1:0];
                lo_o  = {lo_i[DATA_W-2:0], 1'b0};
            end
        end else begin
            acc_o = sum[DATA_W:1];
            lo_o  = {sum[0], lo_i[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes
// on entry, BITS_PER_CYC md_step copies retire bits each CALC cycle, and
// signs are restored when the result is captured. Divide-by-zero and the
// signed MIN/-1 overflow are resolved on entry and finish in one cycle.
module muldiv_unit
    import riscv_m_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int BITS_PER_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              flush,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int N_ITER = DATA_W / BITS_PER_CYC;
    localparam int CNT_W  = $clog2(N_ITER + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_ITER - 1);
    localparam logic [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};

    md_state_e         state_q, state_d;
    m_op_e             op_q, op_d;
    logic              neg_res_q, neg_res_d;   // product / quotient sign
    logic              neg_rem_q, neg_rem_d;   // remainder follows dividend
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] result_q, result_d;

    // Entry decode
    m_op_e             op_in;
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic              div_zero, div_ovf, special;
    logic [DATA_W-1:0] special_res;

    // Datapath chain and result fix-up
    logic [BITS_PER_CYC:0][DATA_W-1:0] acc_ch, lo_ch;
    logic [2*DATA_W-1:0] prod, prod_s;
    logic [DATA_W-1:0]   quo_s, rem_s, calc_res;

    assign acc_ch[0] = acc_q;
    assign lo_ch[0]  = lo_q;

    for (genvar g = 0; g < BITS_PER_CYC; g++) begin : g_step
        md_step #(.DATA_W(DATA_W)) u_step (
            .is_div (op_is_div(op_q)),
            .opb    (opb_q),
            .acc_i  (acc_ch[g]),
            .lo_i   (lo_ch[g]),
            .acc_o  (acc_ch[g+1]),
            .lo_o   (lo_ch[g+1])
        );
    end

    // Decode the incoming op: magnitudes, signs and the one-cycle specials
    always_comb begin
        op_in    = m_op_e'(funct3);
        a_neg    = op_a_signed(op_in) & op_a[DATA_W-1];
        b_neg    = op_b_signed(op_in) & op_b[DATA_W-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        div_zero = (op_b == '0);
        div_ovf  = ((op_in == M_DIV) || (op_in == M_REM)) &&
                   (op_a == MIN_VAL) && (op_b == '1);
        special  = op_is_div(op_in) & (div_zero | div_ovf);
        if (div_zero)
            special_res = op_is_rem(op_in) ? op_a : '1;
        else
            special_res = op_is_rem(op_in) ? '0 : MIN_VAL;
    end

    // Restore signs on the value leaving the last step of the chain
    always_comb begin
        prod   = {acc_ch[BITS_PER_CYC], lo_ch[BITS_PER_CYC]};
        prod_s = neg_res_q ? -prod : prod;
        quo_s  = neg_res_q ? -lo_ch[BITS_PER_CYC] : lo_ch[BITS_PER_CYC];
        rem_s  = neg_rem_q ? -acc_ch[BITS_PER_CYC] : acc_ch[BITS_PER_CYC];
        if (op_is_div(op_q))
            calc_res = op_is_rem(op_q) ? rem_s : quo_s;
        else if (op_q == M_MUL)
            calc_res = prod_s[DATA_W-1:0];
        else
            calc_res = prod_s[2*DATA_W-1:DATA_W];
    end

    // Next-state logic for the sequencer and datapath registers
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        case (state_q)
            MD_IDLE: begin
                if (start && !flush) begin
                    op_d      = op_in;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    acc_d     = '0;
                    lo_d      = a_mag;
                    opb_d     = b_mag;
                    cnt_d     = '0;
                    if (special) begin
                        result_d = special_res;
                        state_d  = MD_DONE;
                    end else begin
                        state_d  = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                acc_d = acc_ch[BITS_PER_CYC];
                lo_d  = lo_ch[BITS_PER_CYC];
                cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d = calc_res;
                    state_d  = MD_DONE;
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        // A flush abandons whatever is in flight without touching the result
        if (flush) begin
            state_d  = MD_IDLE;
            result_d = result_q;
        end
    end

    // State registers, synchronous reset clears everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            op_q      <= M_MUL;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            opb_q     <= opb_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q != MD_IDLE);
    assign done   = (state_q == MD_DONE);
    assign stall  = ((state_q == MD_IDLE) & start & ~flush) | (state_q == MD_CALC);
    assign result = result_q;

endmodule
